// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a register-file backed synchronous FIFO.
// The storage array sits outside this block: it is written at w_addr when wr_en is high,
// and r_addr drives its combinational read port. Full and empty are tracked as explicit
// registered flags, so the pointers carry no extra wrap bit.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_CNT      = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic [ADDR_WIDTH-1:0] w_ptr_inc;
  logic [ADDR_WIDTH-1:0] r_ptr_inc;
  logic [ADDR_WIDTH-1:0] ptr_diff;

  // Decide which requests are accepted; a push into a full FIFO is allowed only alongside a pop
  always_comb begin
    push_ok   = wr & (~full_q | rd);
    pop_ok    = rd & ~empty_q;
    w_ptr_inc = w_ptr_q + 1'b1;
    r_ptr_inc = r_ptr_q + 1'b1;
    ptr_diff  = w_ptr_q - r_ptr_q;
  end

  // Next-state computation for pointers, occupancy, status and sticky error flags
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    empty_d     = empty_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;

    if (push_ok) begin
      w_ptr_d = w_ptr_inc;
    end
    if (pop_ok) begin
      r_ptr_d = r_ptr_inc;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + ONE_CNT;
      empty_d = 1'b0;
      full_d  = (w_ptr_inc == r_ptr_q);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - ONE_CNT;
      full_d  = 1'b0;
      empty_d = (r_ptr_inc == w_ptr_q);
    end

    // A new error in the same cycle as clr_err keeps the flag set
    if (wr && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (rd && !pop_ok) begin
      underflow_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output decode: storage addresses follow the pointers, thresholds come from occupancy
  always_comb begin
    w_addr       = w_ptr_q;
    r_addr       = r_ptr_q;
    wr_en        = push_ok;
    full         = full_q;
    empty        = empty_q;
    count        = count_q;
    almost_full  = (count_q >= DEPTH_M1_CNT);
    almost_empty = (count_q <= ONE_CNT);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Consistency checks between the explicit flags, occupancy and pointer distance
  a_not_full_and_empty : assert property (
    @(posedge clk) disable iff (!reset) !(full_q && empty_q));

  a_count_matches_ptrs : assert property (
    @(posedge clk) disable iff (!reset)
      full_q ? (count_q == DEPTH_CNT) : (count_q == {1'b0, ptr_diff}));

  a_empty_decode : assert property (
    @(posedge clk) disable iff (!reset) empty_q == (count_q == '0));

  a_full_decode : assert property (
    @(posedge clk) disable iff (!reset) full_q == (count_q == DEPTH_CNT));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: drives fifo_ctrl with a small storage array attached, compares status
// against a queue-level reference model and checks read data through a scoreboard.
module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          clr_err;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  logic [7:0]    wr_data;
  logic [7:0]    mem [DEPTH];

  int            n_checks;
  int            n_fail;

  // Reference model state: occupancy, accepted push/pop totals mapped to slots, sticky flags
  int            m_cnt;
  int            m_wp;
  int            m_rp;
  bit            m_ovf;
  bit            m_unf;
  logic [7:0]    exp_q[$];

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .wr_en        (wr_en),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array owned by the bench, written through the controller's address interface
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= wr_data;
  end

  task automatic checkValue(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Read-side monitor: whenever the consumer pops a non-empty FIFO, the front of the scoreboard must be on the read port
  always @(negedge clk) begin
    if (reset && rd && !empty) begin
      if (exp_q.size() == 0) begin
        checkValue("read_data_unexpected", 1, 0);
      end else begin
        checkValue("read_data", int'(mem[r_addr]), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic resetModel();
    m_cnt = 0;
    m_wp  = 0;
    m_rp  = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.delete();
  endtask

  task automatic checkOutput();
    checkValue("count",        int'(count),        m_cnt);
    checkValue("full",         int'(full),         int'(m_cnt == DEPTH));
    checkValue("empty",        int'(empty),        int'(m_cnt == 0));
    checkValue("almost_full",  int'(almost_full),  int'(m_cnt >= DEPTH - 1));
    checkValue("almost_empty", int'(almost_empty), int'(m_cnt <= 1));
    checkValue("overflow",     int'(overflow),     int'(m_ovf));
    checkValue("underflow",    int'(underflow),    int'(m_unf));
    checkValue("w_addr",       int'(w_addr),       m_wp);
    checkValue("r_addr",       int'(r_addr),       m_rp);
  endtask

  // Called just after a rising edge: drives one cycle of requests, checks wr_en, then the post-edge state
  task automatic applyStimulus(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit push_acc;
    bit pop_acc;
    wr      = w;
    rd      = r;
    clr_err = c;
    wr_data = d;
    push_acc = w && ((m_cnt < DEPTH) || r);
    pop_acc  = r && (m_cnt > 0);
    if (push_acc) exp_q.push_back(d);
    #1;
    checkValue("wr_en", int'(wr_en), int'(push_acc));
    @(posedge clk);
    m_ovf = (w && !push_acc) || (m_ovf && !c);
    m_unf = (r && !pop_acc) || (m_unf && !c);
    if (push_acc) m_wp = (m_wp + 1) % DEPTH;
    if (pop_acc)  m_rp = (m_rp + 1) % DEPTH;
    m_cnt = m_cnt + int'(push_acc) - int'(pop_acc);
    #1;
    checkOutput();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    clr_err  = 1'b0;
    wr_data  = 8'h00;
    resetModel();

    // Reset values while held in reset
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput();
    checkValue("wr_en_reset", int'(wr_en), 0);
    reset = 1'b1;
    $display("[TB] reset released");

    // Idle after reset
    applyStimulus(0, 0, 0, 8'h00);

    // Fill to full, attempt a fifth push, then drain in order
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 8'hA1 + 8'(i));
    applyStimulus(1, 0, 0, 8'hA5);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);

    // Pointer wrap-around
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'hE0 + 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'hE3 + 8'(i));
    applyStimulus(1, 0, 0, 8'hE6);

    // Simultaneous push and pop while full, then drain
    applyStimulus(1, 1, 0, 8'hB5);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00);

    // Simultaneous push and pop while empty, then error clear behaviour
    applyStimulus(1, 1, 0, 8'hC7);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);

    // Asynchronous reset in the middle of a cycle with two entries held
    applyStimulus(1, 0, 0, 8'h11);
    applyStimulus(1, 0, 0, 8'h12);
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    resetModel();
    checkOutput();
    checkValue("wr_en_async_reset", int'(wr_en), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1, 0, 0, 8'hD9);
    applyStimulus(0, 1, 0, 8'h00);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    applyStimulus(0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
